// File: rtl/dcache_types.sv
// Shared types and constants for the 2-way write-back data cache.
package dcache_types;

   localparam int unsigned OFFSET_W   = 5;
   localparam int unsigned WORD_SEL_W = 3;

   typedef logic [255:0] line_t;

   typedef enum logic [1:0] {
      StIdle,
      StResp,
      StWriteback,
      StAllocate
   } dcache_state_t;

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: valid/dirty/tag/data arrays with a combinational read port
// and a write port that either loads a whole line or merges bytes into one word.
module dcache_way
   import dcache_types::*;
#(
   parameter int unsigned S_INDEX = 3,
   parameter int unsigned TAG_W   = 32 - OFFSET_W - S_INDEX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [S_INDEX-1:0]    index,
   input  logic                  load,
   input  logic                  merge,
   input  logic                  clean,
   input  logic [WORD_SEL_W-1:0] word_sel,
   input  logic [3:0]            mbe,
   input  logic [31:0]           wdata,
   input  logic [TAG_W-1:0]      tag_in,
   input  line_t                 line_in,
   output logic                  rd_valid,
   output logic                  rd_dirty,
   output logic [TAG_W-1:0]      rd_tag,
   output line_t                 rd_line
);

   localparam int unsigned Sets = 1 << S_INDEX;

   logic [Sets-1:0]  valid_q;
   logic [Sets-1:0]  dirty_q;
   logic [TAG_W-1:0] tag_q [Sets];
   line_t            line_q [Sets];
   line_t            merged;

   assign rd_valid = valid_q[index];
   assign rd_dirty = dirty_q[index];
   assign rd_tag   = tag_q[index];
   assign rd_line  = line_q[index];

   always_comb begin
      merged = line_q[index];
      for (int b = 0; b < 4; b++) begin
         if (mbe[b]) merged[{word_sel, 2'(b), 3'b000} +: 8] = wdata[b*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (load) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (merge && (mbe != 4'b0000)) begin
         dirty_q[index] <= 1'b1;
      end else if (clean) begin
         dirty_q[index] <= 1'b0;
      end
   end

   // Tag and data contents are deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (load) begin
         tag_q[index]  <= tag_in;
         line_q[index] <= line_in;
      end else if (merge) begin
         line_q[index] <= merged;
      end
   end

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back/write-allocate data cache with 1-bit LRU per set.
// A miss runs optional writeback, then refill, then re-looks up the held request.
module dcache_2way
   import dcache_types::*;
#(
   parameter int unsigned S_INDEX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [3:0]  data_mbe,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_resp,
   output logic [31:0] data_rdata,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [31:0] pmem_address,
   output line_t       pmem_wdata,
   input  line_t       pmem_rdata,
   input  logic        pmem_resp
);

   localparam int unsigned TAG_W = 32 - OFFSET_W - S_INDEX;
   localparam int unsigned Sets  = 1 << S_INDEX;

   dcache_state_t      state_q, state_d;
   logic [Sets-1:0]    lru_q, lru_d;
   logic [31:0]        rdata_d, addr_d;
   logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
   logic [S_INDEX-1:0] miss_index_q, miss_index_d;
   logic               victim_q, victim_d;

   logic [TAG_W-1:0]      req_tag;
   logic [S_INDEX-1:0]    req_index, way_index;
   logic [WORD_SEL_W-1:0] req_word;
   logic                  req, hit, hit_way, victim;
   logic [1:0]            way_valid, way_dirty, way_hit, way_load, way_merge, way_clean;
   logic [TAG_W-1:0]      way_tag [2];
   line_t                 way_line [2];
   line_t                 hit_line;
   logic [31:0]           hit_word, merged_word;
   logic                  unused_addr_bits;

   assign req_tag          = data_addr[31 -: TAG_W];
   assign req_index        = data_addr[OFFSET_W +: S_INDEX];
   assign req_word         = data_addr[2 +: WORD_SEL_W];
   assign req              = data_read | data_write;
   assign unused_addr_bits = ^data_addr[1:0];

   // While a miss is in flight the arrays follow the latched set, not the live address.
   assign way_index = (state_q == StIdle) ? req_index : miss_index_q;

   for (genvar w = 0; w < 2; w++) begin : g_way
      dcache_way #(
         .S_INDEX (S_INDEX),
         .TAG_W   (TAG_W)
      ) u_way (
         .clk      (clk),
         .rst      (rst),
         .index    (way_index),
         .load     (way_load[w]),
         .merge    (way_merge[w]),
         .clean    (way_clean[w]),
         .word_sel (req_word),
         .mbe      (data_mbe),
         .wdata    (data_wdata),
         .tag_in   (miss_tag_q),
         .line_in  (pmem_rdata),
         .rd_valid (way_valid[w]),
         .rd_dirty (way_dirty[w]),
         .rd_tag   (way_tag[w]),
         .rd_line  (way_line[w])
      );
      assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
   end

   assign hit      = |way_hit;
   assign hit_way  = ~way_hit[0];
   assign hit_line = way_line[hit_way];
   assign hit_word = hit_line[{req_word, 5'b00000} +: 32];
   assign victim   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_index]);

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         merged_word[b*8 +: 8] = (data_write && data_mbe[b]) ? data_wdata[b*8 +: 8]
                                                              : hit_word[b*8 +: 8];
      end
   end

   always_comb begin
      state_d      = state_q;
      lru_d        = lru_q;
      rdata_d      = data_rdata;
      addr_d       = pmem_address;
      miss_tag_d   = miss_tag_q;
      miss_index_d = miss_index_q;
      victim_d     = victim_q;
      way_load     = '0;
      way_merge    = '0;
      way_clean    = '0;
      case (state_q)
         StIdle: begin
            if (req && hit) begin
               way_merge[hit_way] = data_write;
               rdata_d            = merged_word;
               lru_d[req_index]   = ~hit_way;
               state_d            = StResp;
            end else if (req) begin
               victim_d     = victim;
               miss_tag_d   = req_tag;
               miss_index_d = req_index;
               if (way_valid[victim] && way_dirty[victim]) begin
                  addr_d  = {way_tag[victim], req_index, {OFFSET_W{1'b0}}};
                  state_d = StWriteback;
               end else begin
                  addr_d  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                  state_d = StAllocate;
               end
            end
         end
         StResp: state_d = StIdle;
         StWriteback: begin
            if (pmem_resp) begin
               way_clean[victim_q] = 1'b1;
               addr_d              = {miss_tag_q, miss_index_q, {OFFSET_W{1'b0}}};
               state_d             = StAllocate;
            end
         end
         StAllocate: begin
            if (pmem_resp) begin
               way_load[victim_q]    = 1'b1;
               lru_d[miss_index_q]   = ~victim_q;
               state_d               = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         lru_q        <= '0;
         data_rdata   <= '0;
         pmem_address <= '0;
         miss_tag_q   <= '0;
         miss_index_q <= '0;
         victim_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         lru_q        <= lru_d;
         data_rdata   <= rdata_d;
         pmem_address <= addr_d;
         miss_tag_q   <= miss_tag_d;
         miss_index_q <= miss_index_d;
         victim_q     <= victim_d;
      end
   end

   assign data_resp  = (state_q == StResp);
   assign pmem_read  = (state_q == StAllocate);
   assign pmem_write = (state_q == StWriteback);
   assign pmem_wdata = way_line[victim_q];

endmodule

// File: tb/tb_dcache_2way.sv
// Scoreboard bench for dcache_2way: expected CPU responses and pmem transfers are queued
// by the stimulus and popped by independent monitor/responder processes.
module tb_dcache_2way;
   import dcache_types::*;

   localparam int MemLat = 3;

   logic        clk, rst;
   logic        data_read, data_write, data_resp;
   logic [3:0]  data_mbe;
   logic [31:0] data_addr, data_wdata, data_rdata, pmem_address;
   logic        pmem_read, pmem_write, pmem_resp;
   line_t       pmem_wdata, pmem_rdata;

   typedef struct {
      logic [31:0] rdata;
      bit          from_pmem;
      int          lat;
      int          issue_cyc;
   } resp_exp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      line_t       wdata;
   } pmem_exp_t;

   resp_exp_t resp_q[$];
   pmem_exp_t pmem_q[$];
   line_t     mem [logic [31:0]];

   int tests = 0, fails = 0, cyc = 0, last_pmem_cyc = 0, overlap = 0;
   bit mem_hold = 0;

   dcache_2way #(.S_INDEX(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_read    (data_read),
      .data_write   (data_write),
      .data_mbe     (data_mbe),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_resp    (data_resp),
      .data_rdata   (data_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input line_t act, input line_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Backing line: word k = {addr[15:0], 16'h000k} unless overridden in mem.
   function automatic line_t line_of(input logic [31:0] a);
      line_t l;
      if (mem.exists(a)) return mem[a];
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 16'(k)};
      return l;
   endfunction

   // Memory responder and pmem scoreboard.
   initial begin
      int cnt;
      pmem_exp_t e;
      cnt        = 0;
      pmem_resp  = 0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         pmem_resp = 0;
         if (pmem_read && pmem_write) overlap++;
         if (!rst || mem_hold || !(pmem_read || pmem_write)) begin
            cnt = 0;
         end else if (++cnt == MemLat) begin
            cnt = 0;
            if (pmem_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pmem: got wr=%0b addr=%0h, expected none",
                        pmem_write, pmem_address);
            end else begin
               e = pmem_q.pop_front();
               check("pmem_kind_is_write", line_t'(pmem_write), line_t'(e.wr));
               check("pmem_address", line_t'(pmem_address), line_t'(e.addr));
               if (e.wr) check("pmem_wdata", pmem_wdata, e.wdata);
            end
            if (pmem_write) mem[pmem_address] = pmem_wdata;
            else pmem_rdata = line_of(pmem_address);
            pmem_resp     = 1;
            last_pmem_cyc = cyc;
         end
      end
   end

   // CPU response monitor.
   always @(negedge clk) begin
      resp_exp_t e;
      if (rst && data_resp) begin
         if (resp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got rdata=%0h, expected no data_resp", data_rdata);
         end else begin
            e = resp_q.pop_front();
            check("data_rdata", line_t'(data_rdata), line_t'(e.rdata));
            check(e.from_pmem ? "latency_after_pmem_resp" : "latency_after_request",
                  line_t'(cyc - (e.from_pmem ? last_pmem_cyc : e.issue_cyc)), line_t'(e.lat));
         end
      end
   end

   task automatic exp_rd(input logic [31:0] a);
      pmem_q.push_back('{1'b0, a, '0});
   endtask

   task automatic exp_wr(input logic [31:0] a, input line_t l);
      pmem_q.push_back('{1'b1, a, l});
   endtask

   task automatic access(input bit wr, input logic [31:0] a, input logic [3:0] mbe,
                         input logic [31:0] wd, input logic [31:0] exp, input bit from_pmem,
                         input int lat);
      bit done;
      @(negedge clk);
      data_read  = !wr;
      data_write = wr;
      data_addr  = a;
      data_mbe   = mbe;
      data_wdata = wd;
      resp_q.push_back('{exp, from_pmem, lat, cyc});
      done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (data_resp) done = 1;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL resp_timeout: got no data_resp for addr %0h, expected one", a);
         resp_q.delete();
      end
      data_read  = 0;
      data_write = 0;
   endtask

   task automatic wait_pmem_read(output bit seen);
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (pmem_read) seen = 1;
      end
   endtask

   initial begin
      line_t l40, wb;
      bit    seen;
      rst = 0; data_read = 0; data_write = 0; data_mbe = 0; data_addr = 0; data_wdata = 0;
      l40 = line_of(32'h40);
      l40[95:64] = 32'hDEAD_BEEF;
      mem[32'h40] = l40;
      wb = l40;
      wb[95:64] = 32'hDE22_BE44;

      repeat (2) @(negedge clk);
      check("reset_data_resp", line_t'(data_resp), '0);
      check("reset_data_rdata", line_t'(data_rdata), '0);
      check("reset_pmem_read", line_t'(pmem_read), '0);
      check("reset_pmem_write", line_t'(pmem_write), '0);
      check("reset_pmem_address", line_t'(pmem_address), '0);
      rst = 1;

      // Cold miss, store hit merge, read back, second way fill, dirty eviction.
      exp_rd(32'h40);
      access(0, 32'h48, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 2);
      access(1, 32'h48, 4'b0101, 32'h1122_3344, 32'hDE22_BE44, 0, 1);
      access(0, 32'h48, 4'h0, 32'h0, 32'hDE22_BE44, 0, 1);
      exp_rd(32'h140);
      access(0, 32'h144, 4'h0, 32'h0, 32'h0140_0001, 1, 2);
      exp_wr(32'h40, wb);
      exp_rd(32'h240);
      access(0, 32'h24C, 4'h0, 32'h0, 32'h0240_0003, 1, 2);

      // LRU ordering in set 3: A, B, A, then C evicts B.
      exp_rd(32'h60);
      access(0, 32'h60, 4'h0, 32'h0, 32'h0060_0000, 1, 2);
      exp_rd(32'h160);
      access(0, 32'h160, 4'h0, 32'h0, 32'h0160_0000, 1, 2);
      access(0, 32'h64, 4'h0, 32'h0, 32'h0060_0001, 0, 1);
      exp_rd(32'h260);
      access(0, 32'h268, 4'h0, 32'h0, 32'h0260_0002, 1, 2);
      access(0, 32'h6C, 4'h0, 32'h0, 32'h0060_0003, 0, 1);
      exp_rd(32'h160);
      access(0, 32'h160, 4'h0, 32'h0, 32'h0160_0000, 1, 2);

      // Write miss allocates, then merges.
      exp_rd(32'hC0);
      access(1, 32'hC4, 4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 2);

      // Request dropped mid-miss: refill completes silently, later access hits.
      exp_rd(32'hE0);
      @(negedge clk);
      data_read = 1;
      data_addr = 32'hE0;
      wait_pmem_read(seen);
      check("drop_pmem_read_seen", line_t'(seen), line_t'(1));
      data_read = 0;
      repeat (10) @(negedge clk);
      access(0, 32'hE4, 4'h0, 32'h0, 32'h00E0_0001, 0, 1);

      // Async reset during ALLOCATE.
      mem_hold = 1;
      @(negedge clk);
      data_read = 1;
      data_addr = 32'hA0;
      wait_pmem_read(seen);
      check("rst_pmem_read_seen", line_t'(seen), line_t'(1));
      rst = 0;
      #1;
      check("rst_pmem_read_drop", line_t'(pmem_read), '0);
      check("rst_pmem_write_low", line_t'(pmem_write), '0);
      check("rst_data_resp_low", line_t'(data_resp), '0);
      data_read = 0;
      repeat (3) @(negedge clk);
      rst = 1;
      mem_hold = 0;
      exp_rd(32'h60);
      access(0, 32'h60, 4'h0, 32'h0, 32'h0060_0000, 1, 2);

      // Zero-mask store hit: no change, line stays clean so eviction has no writeback.
      access(1, 32'h64, 4'h0, 32'hFFFF_FFFF, 32'h0060_0001, 0, 1);
      access(0, 32'h64, 4'h0, 32'h0, 32'h0060_0001, 0, 1);
      exp_rd(32'h160);
      access(0, 32'h160, 4'h0, 32'h0, 32'h0160_0000, 1, 2);
      exp_rd(32'h260);
      access(0, 32'h260, 4'h0, 32'h0, 32'h0260_0000, 1, 2);

      repeat (5) @(negedge clk);
      check("resp_queue_drained", line_t'(resp_q.size()), '0);
      check("pmem_queue_drained", line_t'(pmem_q.size()), '0);
      check("pmem_read_write_overlap", line_t'(overlap), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected bench to finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dcache_2way.md
Name: dcache_2way

Overview:
- Data cache that answers the CPU datapath's data port (data_read/data_write/data_mbe/data_addr/data_wdata in; data_resp/data_rdata out).
- 2-way set-associative, write-back, write-allocate, 32-byte lines, 1-bit LRU per set.
- Sits between the MEM stage and the 256-bit line port to the physical-memory adaptor.
- Holds each request until it is serviced; a miss is resolved by optional writeback, then refill, then re-lookup.

Parameters:
- S_INDEX, 3, index bits (2^S_INDEX sets).
- TAG_W, 32-5-S_INDEX, tag width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- data_read  in  1  CPU load request, held until data_resp.
- data_write  in  1  CPU store request, held until data_resp.
- data_mbe  in  4  store byte enables.
- data_addr  in  32  byte address; [1:0] ignored, [4:2] word, [4+S_INDEX:5] index, rest tag.
- data_wdata  in  32  store data.
- data_resp  out  1  one-cycle completion pulse.
- data_rdata  out  32  full addressed word, valid while data_resp=1.
- pmem_read  out  1  line refill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line address, [4:0]=0.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  refill line.
- pmem_resp  in  1  line transfer done, one cycle.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - all valid, dirty and LRU bits = 0.
  - data_resp=0, data_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0.
  - Tag and data arrays are not cleared.
- Reset mid-transaction: pmem_read/pmem_write drop immediately and the transaction is abandoned. The memory side must ignore the stale pmem_resp.
- Storage: flops, combinational read, written at the clock edge.
- States: IDLE, RESP, WRITEBACK, ALLOCATE.
- IDLE with data_read|data_write, lookup both ways combinationally:
  - Hit (way w): the cycle N edge does the following.
    - Store only: bytes i with data_mbe[i]=1 of word [4:2] take data_wdata bytes; dirty[w]=1 if data_mbe!=0.
    - data_rdata <= post-merge word.
    - LRU[set] <= ~w.
    - Go to RESP.
  - Miss, victim selection:
    - First invalid way (way 0 preferred).
    - Otherwise way LRU[set].
    - valid & dirty victim -> WRITEBACK; else -> ALLOCATE.
- RESP:
  - data_resp=1 for exactly one cycle (N+1), then IDLE.
  - The request is not re-serviced in this cycle.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line.
  - On pmem_resp: dirty[victim]=0, go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={req tag, index, 5'b0}.
  - On pmem_resp: line <= pmem_rdata, tag written, valid=1, dirty=0, LRU[set] <= ~victim, go to IDLE.
  - The re-lookup then hits.
- Latency:
  - Hit: data_resp 1 cycle after request presentation.
  - Clean miss: refill latency + 2.
  - Dirty miss: writeback + refill + 2.
- Simultaneous data_read & data_write is illegal; it is treated as a write.
- Request dropped mid-miss: the miss sequence completes, no data_resp is issued, and the cache returns to IDLE.
- pmem_read and pmem_write are never high together.
- pmem outputs are driven from state only, so they are stable while waiting.
- Every state holds indefinitely until its pmem_resp (no timeout).

Decomposition:
- Package dcache_types:
  - state enum dcache_state_t.
  - line type (logic [255:0]).
  - localparams OFFSET_W=5, WORD_SEL_W=3.
- Sub-module dcache_way, instantiated twice:
  - Per-way arrays for valid, dirty, tag and data.
  - Combinational read port; write port with line-load and word/byte-merge modes.
  - Async active-low clear of valid/dirty.
- Top level holds the FSM, the LRU array, hit/victim logic and the output registers.

Test Plan:
- Cold read miss: read 0x0000_0040 with pmem_rdata word2=0xDEAD_BEEF, addr 0x48 ->
  - pmem_read with pmem_address=0x40.
  - data_resp with data_rdata=0xDEAD_BEEF, 2 cycles after pmem_resp.
  - pmem_write never asserted.
- Store hit byte merge: line word at 0x48 = 0xDEAD_BEEF, write 0x48 with mbe=4'b0101, wdata=0x1122_3344 ->
  - data_resp 1 cycle later, no pmem traffic.
  - Read 0x48 returns 0xDE22_BE44.
- Dirty eviction with the above state:
  - Fill set 2 with tags A and B; A is dirty and LRU.
  - Miss on tag C -> pmem_write first at {A,2,0} with the merged line, then pmem_read at {C,2,0}, then data_resp.
- LRU ordering: touch tag A, then B, then A; miss on C -> B is evicted, and a subsequent access to A hits.
- Async reset during ALLOCATE: assert rst=0 while pmem_read=1 ->
  - pmem_read=0 immediately.
  - After release, a read of a previously cached line misses (valid cleared).
- Write with mbe=4'b0000 on a hit -> data_resp=1, line unchanged, later eviction of that line produces no writeback.
